// File: rtl/nibble_serial_adder_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : nibble_serial_adder_ctrl_if
// Brief    : Request/result bundle for the nibble-serial adder sequencer.
//            The sub signal exists only when SUB_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
interface nibble_serial_adder_ctrl_if #(
    parameter int NIBBLES = 4
);
    localparam int W = 4 * NIBBLES;

    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
`ifdef SUB_EN
    logic         sub;
`endif
    logic         busy;
    logic         done;
    logic [W-1:0] s;
    logic         cout;
    logic         ovf;

    modport master (
`ifdef SUB_EN
        output sub,
`endif
        output start, a, b, cin,
        input  busy, done, s, cout, ovf
    );

    modport slave (
`ifdef SUB_EN
        input  sub,
`endif
        input  start, a, b, cin,
        output busy, done, s, cout, ovf
    );
endinterface
`default_nettype wire

// File: rtl/nibble_serial_adder_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : nibble_serial_adder_ctrl
// Brief    : Wide adder built from one 4-bit slice, one nibble per clock,
//            LSB first. Define SUB_EN to add the subtract option.
// Revision : 1.0 - initial release
// ============================================================================
module nibble_serial_adder_ctrl #(
    parameter int NIBBLES = 4
) (
    input  logic                          clk,
    input  logic                          rst_n,
    nibble_serial_adder_ctrl_if.slave     bus
);
    localparam int W     = 4 * NIBBLES;
    localparam int IDX_W = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
    localparam logic [IDX_W-1:0] c_last_idx = IDX_W'(NIBBLES - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_next;
    logic [W-1:0]     r_a;
    logic [W-1:0]     r_b;
    logic             r_carry;
    logic [IDX_W-1:0] r_idx;
    logic [3:0]       r_s_nib [NIBBLES];
    logic             r_cout;
    logic             r_ovf;

    logic             w_accept;
    logic             w_last;
    logic [W-1:0]     w_b_eff;
    logic             w_cin_eff;
    logic [3:0]       w_a_nib [NIBBLES];
    logic [3:0]       w_b_nib [NIBBLES];
    logic [4:0]       w_slice_sum;
    logic [W-1:0]     w_s;

    // Effective operand: subtraction is A + ~B + 1, folded in at acceptance
`ifdef SUB_EN
    assign w_b_eff   = bus.sub ? ~bus.b : bus.b;
    assign w_cin_eff = bus.sub | bus.cin;
`else
    assign w_b_eff   = bus.b;
    assign w_cin_eff = bus.cin;
`endif

    assign w_accept = (r_state != ST_RUN) && bus.start;
    assign w_last   = (r_idx == c_last_idx);

    always_comb begin
        for (int i = 0; i < NIBBLES; i++) begin
            w_a_nib[i]     = r_a[4*i +: 4];
            w_b_nib[i]     = r_b[4*i +: 4];
            w_s[4*i +: 4]  = r_s_nib[i];
        end
    end

    assign w_slice_sum = {1'b0, w_a_nib[r_idx]} + {1'b0, w_b_nib[r_idx]} + {4'b0000, r_carry};

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE: if (bus.start) w_next = ST_RUN;
            ST_RUN:  if (w_last)    w_next = ST_DONE;
            ST_DONE: w_next = bus.start ? ST_RUN : ST_IDLE;
            default: w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a     <= '0;
            r_b     <= '0;
            r_carry <= 1'b0;
            r_idx   <= '0;
            r_cout  <= 1'b0;
            r_ovf   <= 1'b0;
        end else if (w_accept) begin
            r_a     <= bus.a;
            r_b     <= w_b_eff;
            r_carry <= w_cin_eff;
            r_idx   <= '0;
        end else if (r_state == ST_RUN) begin
            r_carry <= w_slice_sum[4];
            if (w_last) begin
                r_idx  <= '0;
                r_cout <= w_slice_sum[4];
                // r_b already holds the effective operand, so one rule covers add and subtract
                r_ovf  <= (r_a[W-1] == r_b[W-1]) && (w_slice_sum[3] != r_a[W-1]);
            end else begin
                r_idx  <= r_idx + 1'b1;
            end
        end
    end

    for (genvar gi = 0; gi < NIBBLES; gi++) begin : g_nib
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_s_nib[gi] <= 4'h0;
            end else if ((r_state == ST_RUN) && (r_idx == IDX_W'(gi))) begin
                r_s_nib[gi] <= w_slice_sum[3:0];
            end
        end
    end

    assign bus.busy = (r_state == ST_RUN);
    assign bus.done = (r_state == ST_DONE);
    assign bus.s    = w_s;
    assign bus.cout = r_cout;
    assign bus.ovf  = r_ovf;

endmodule
`default_nettype wire

// File: tb/tb_nibble_serial_adder_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_nibble_serial_adder_ctrl
// Brief    : Scoreboard bench: directed corner cases plus random operands
//            against an arithmetic reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_nibble_serial_adder_ctrl;
    localparam int N = 4;
    localparam int W = 4 * N;

    typedef struct packed {
        logic [W-1:0] s;
        logic         cout;
        logic         ovf;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    nibble_serial_adder_ctrl_if #(.NIBBLES(N)) bus ();
    nibble_serial_adder_ctrl #(.NIBBLES(N)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    exp_t q[$];
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    int   done_cnt = 0;
    int   acc_cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b,
                                   input logic cin, input logic sub);
        logic [W-1:0] bp;
        logic         ci;
        logic [W:0]   sum;
        exp_t         e;
        bp     = sub ? ~b : b;
        ci     = sub ? 1'b1 : cin;
        sum    = {1'b0, a} + {1'b0, bp} + (W+1)'(ci);
        e.s    = sum[W-1:0];
        e.cout = sum[W];
        e.ovf  = (a[W-1] == bp[W-1]) && (sum[W-1] != a[W-1]);
        return e;
    endfunction

    // Monitor: every DONE pulse consumes one expected result
    always @(negedge clk) begin : mon
        exp_t e;
        if (rst_n === 1'b1 && bus.done === 1'b1) begin
            done_cnt++;
            if (q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done: got done=1 expected no result pending (t=%0t)", $time);
            end else begin
                e = q.pop_front();
                chk("sum", 32'(bus.s), 32'(e.s));
                chk("cout", 32'(bus.cout), 32'(e.cout));
                chk("ovf", 32'(bus.ovf), 32'(e.ovf));
                chk("busy_at_done", 32'(bus.busy), 32'(0));
            end
        end
    end

    // Drive a request at the current (negedge) time; returns 1ns after the edge
    task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin,
                         input logic sub, input exp_t e, input bit accepted);
        bus.start = 1'b1;
        bus.a     = a;
        bus.b     = b;
        bus.cin   = cin;
`ifdef SUB_EN
        bus.sub   = sub;
`endif
        if (accepted) q.push_back(e);
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        if (accepted) begin
            acc_cyc = cyc;
            chk("busy_after_start", 32'(bus.busy), 32'(1));
        end
    endtask

    task automatic wait_done(output int busy_seen);
        bit ok;
        busy_seen = 0;
        ok = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (bus.done === 1'b1) begin
                ok = 1;
                break;
            end
            if (bus.busy === 1'b1) busy_seen++;
        end
        if (!ok) begin
            checks++;
            errors++;
            $display("FAIL done_timeout: got no done in 40 cycles expected done (t=%0t)", $time);
        end
    endtask

    task automatic run_one(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin,
                           input logic sub, input exp_t e);
        int bs;
        issue(a, b, cin, sub, e, 1'b1);
        wait_done(bs);
        chk("latency", 32'(cyc - acc_cyc), 32'(N));
        chk("busy_cycles", 32'(bs), 32'(N));
    endtask

    initial begin : stim
        int   bs;
        int   d1;
        int   dc0;
        logic [W-1:0] ra, rb;
        logic rc, rs;

        rst_n     = 1'b0;
        bus.start = 1'b0;
        bus.a     = '0;
        bus.b     = '0;
        bus.cin   = 1'b0;
`ifdef SUB_EN
        bus.sub   = 1'b0;
`endif
        repeat (3) @(negedge clk);
        chk("rst_busy", 32'(bus.busy), 32'(0));
        chk("rst_done", 32'(bus.done), 32'(0));
        chk("rst_s", 32'(bus.s), 32'(0));
        chk("rst_cout_ovf", 32'({bus.cout, bus.ovf}), 32'(0));
        rst_n = 1'b1;
        @(negedge clk);

        // Directed arithmetic corners (back-to-back after the first)
        run_one(16'h1234, 16'h4321, 1'b0, 1'b0, exp_t'{16'h5555, 1'b0, 1'b0});
        run_one(16'hFFFF, 16'h0001, 1'b0, 1'b0, exp_t'{16'h0000, 1'b1, 1'b0});
        run_one(16'hFFFF, 16'h0001, 1'b1, 1'b0, exp_t'{16'h0001, 1'b1, 1'b0});
        run_one(16'h7FFF, 16'h0001, 1'b0, 1'b0, exp_t'{16'h8000, 1'b0, 1'b1});
        run_one(16'h8000, 16'h8000, 1'b0, 1'b0, exp_t'{16'h0000, 1'b1, 1'b1});

        // START during RUN ignored, START during DONE accepted
        @(negedge clk);
        dc0 = done_cnt;
        issue(16'h1111, 16'h2222, 1'b0, 1'b0, exp_t'{16'h3333, 1'b0, 1'b0}, 1'b1);
        @(negedge clk);
        issue(16'hAAAA, 16'h5555, 1'b1, 1'b0, exp_t'{16'h0000, 1'b0, 1'b0}, 1'b0);
        wait_done(bs);
        d1 = cyc;
        issue(16'h8000, 16'h8000, 1'b1, 1'b0, exp_t'{16'h0001, 1'b1, 1'b1}, 1'b1);
        wait_done(bs);
        chk("b2b_spacing", 32'(cyc - d1), 32'(N + 1));
        repeat (4) @(negedge clk);
        chk("done_count", 32'(done_cnt - dc0), 32'(2));

        // Asynchronous reset during the third nibble
        issue(16'h9999, 16'h9999, 1'b0, 1'b0, exp_t'{16'h3332, 1'b1, 1'b1}, 1'b1);
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("abort_busy", 32'(bus.busy), 32'(0));
        chk("abort_s", 32'(bus.s), 32'(0));
        chk("abort_cout", 32'(bus.cout), 32'(0));
        chk("abort_ovf", 32'(bus.ovf), 32'(0));
        #3;
        q.delete();
        rst_n = 1'b1;
        dc0 = done_cnt;
        repeat (8) @(negedge clk);
        chk("no_done_after_abort", 32'(done_cnt - dc0), 32'(0));
        chk("idle_after_abort", 32'({bus.busy, bus.done}), 32'(0));
        run_one(16'h0123, 16'h0456, 1'b0, 1'b0, exp_t'{16'h0579, 1'b0, 1'b0});

`ifdef SUB_EN
        run_one(16'h0005, 16'h0007, 1'b0, 1'b1, exp_t'{16'hFFFE, 1'b0, 1'b0});
        run_one(16'h8000, 16'h0001, 1'b0, 1'b1, exp_t'{16'h7FFF, 1'b1, 1'b1});
`endif

        // Random operands against the reference model
        for (int i = 0; i < 40; i++) begin
            ra = W'($urandom);
            rb = W'($urandom);
            rc = 1'($urandom_range(1, 0));
`ifdef SUB_EN
            rs = 1'($urandom_range(1, 0));
`else
            rs = 1'b0;
`endif
            repeat ($urandom_range(2, 0)) @(negedge clk);
            run_one(ra, rb, rc, rs, model(ra, rb, rc, rs));
        end

        repeat (3) @(negedge clk);
        chk("queue_empty", 32'(q.size()), 32'(0));
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/nibble_serial_adder_ctrl.md
# nibble_serial_adder_ctrl

Sequencer that performs a wide (4·NIBBLES-bit) addition by time-multiplexing a single 4-bit fast-adder slice (A + B + carry-in → 4-bit sum + carry-out), one nibble per clock, LSB nibble first. It latches operands on a start request, sequences the nibbles through the slice, and holds a registered carry between nibbles. When finished it presents the wide sum, carry-out and signed overflow. It sits between a host/bus requester and the 4-bit adder datapath, trading latency for adder area.

## Interface
Parameters:
- NIBBLES, default 4: operand width in nibbles; W = 4·NIBBLES; legal range 1..16.

Ports:
- Clock and reset: one clock; reset is asynchronous and active-low.
- CLK  in  1  clock; all state changes on the rising edge.
- RST_N  in  1  asynchronous, active-low reset.
- START  in  1  request; accepted only in IDLE or DONE.
- A  in  W  operand A; sampled on the accepting edge.
- B  in  W  operand B; sampled on the accepting edge.
- CIN  in  1  initial carry-in; sampled on the accepting edge.
- SUB  in  1  subtract select; sampled on the accepting edge. Present only with SUB_EN.
- BUSY  out  1  high in RUN.
- DONE  out  1  one-cycle pulse; result valid.
- S  out  W  registered sum; held until the next accepted START.
- COUT  out  1  carry out of the MSB nibble.
- OVF  out  1  two's-complement overflow of the W-bit result.

## Operation
- FSM states: IDLE, RUN, DONE. Reset state is IDLE.
- IDLE/DONE with START=1:
  - Latch A, B and CIN into operand/carry registers.
  - Clear the nibble index IDX to 0.
  - Go to RUN.
- IDLE with START=0: stay in IDLE.
- DONE with START=0: go to IDLE.
- RUN, each cycle:
  - Compute slice_A = Areg[4·IDX+3:4·IDX], slice_B = Breg nibble IDX, carry-in = carry register.
  - Write the 4-bit slice sum into S nibble IDX.
  - Load the slice carry-out into the carry register.
  - Increment IDX.
  - When IDX = NIBBLES−1, go to DONE after this nibble.
- START in RUN is ignored. Operands are not re-sampled and no error is flagged.
- Arithmetic: result is {COUT, S} = A + B + CIN, modulo 2^(W+1). Any nibble carry propagates to the next nibble.
- OVF = (A[W−1] == B'[W−1]) && (S[W−1] != A[W−1]), where B' is the effective B operand. It is evaluated on the final nibble and registered.
- Reset values: BUSY=0, DONE=0, S=0, COUT=0, OVF=0, IDX=0, operand registers 0.
- Reset asserted mid-operation: all outputs and state return to reset values immediately (asynchronously). A partial S is never exposed after reset. No DONE is generated for the aborted request.
- NIBBLES=1: RUN lasts exactly one cycle.

## Timing
- START accepted at edge k:
  - BUSY rises after edge k.
  - Nibble i is computed in the cycle between edges k+i and k+i+1.
  - S nibble i becomes visible after edge k+i+1.
- After edge k+NIBBLES:
  - DONE=1, BUSY=0.
  - S, COUT and OVF are final.
  - Latency from START to DONE is NIBBLES cycles.
- DONE is high for exactly one cycle.
- Back-to-back requests: START high during DONE is accepted at that edge. The next DONE follows NIBBLES cycles later, giving a throughput of one result per NIBBLES+1 cycles.
- S is not stable during RUN. Consumers sample S only on DONE, or at any time while in IDLE.

## Configuration
- SUB_EN defined:
  - SUB port exists.
  - When SUB=1 at acceptance, the B register latches ~B and the carry register latches 1, so CIN is ignored. The result is A − B.
  - COUT=1 means no borrow.
  - OVF uses ~B as B'.
- SUB_EN undefined:
  - No SUB port and no inversion logic.
  - Adder only; B' = B.

## Test plan
All scenarios use NIBBLES=4.
1. A=0x1234, B=0x4321, CIN=0, START at edge k → BUSY for 4 cycles; DONE at edge k+4; S=0x5555, COUT=0, OVF=0.
2. A=0xFFFF, B=0x0001, CIN=0 → full ripple across all nibbles; S=0x0000, COUT=1, OVF=0. Repeat with CIN=1 → S=0x0001, COUT=1.
3. A=0x7FFF, B=0x0001 → S=0x8000, COUT=0, OVF=1. Also A=0x8000, B=0x8000 → S=0x0000, COUT=1, OVF=1.
4. Pulse START=1 during cycle 2 of RUN with different operands → ignored; first result is unchanged; DONE occurs once. Then assert START while DONE=1 → accepted; second DONE arrives exactly 5 cycles after the first.
5. Drop RST_N for half a cycle during the 3rd nibble → BUSY, S, COUT and OVF go to 0 immediately; state is IDLE; no DONE appears. The next START completes normally.
6. (SUB_EN) A=0x0005, B=0x0007, SUB=1 → S=0xFFFE, COUT=0. A=0x8000, B=0x0001, SUB=1 → S=0x7FFF, COUT=1, OVF=1.
